wb_port_arb: RTL and testbench
==============================

# wb_port_arb

Write-port arbiter for the register file. It shares the single regfile write port between two writers: the in-order pipeline writeback, driven from the mem/wb stage, and results from the multi-cycle unit (mul/div, `mdu`). Multi-cycle results are buffered in a 2-entry FIFO and written when the pipeline leaves the port idle. A starvation counter forces a one-cycle pipeline stall so that buffered results always drain.

## Interface
Parameters:
- `RADDR_WIDTH`, default 5: register address width.
- `RDATA_WIDTH`, default 32: register data width.
- `STARVE_LIMIT`, default 4: number of consecutive lost arbitrations by a non-empty buffer before a stall is forced. Legal range 1..15.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `pipe_we_i`  in  1  pipeline write request from mem/wb.
- `pipe_waddr_i`  in  RADDR_WIDTH  pipeline destination register.
- `pipe_wdata_i`  in  RDATA_WIDTH  pipeline write data.
- `mdu_valid_i`  in  1  mdu result valid.
- `mdu_ready_o`  out  1  buffer can accept a result (count < 2).
- `mdu_waddr_i`  in  RADDR_WIDTH  mdu destination register.
- `mdu_wdata_i`  in  RDATA_WIDTH  mdu result data.
- `stall_o`  out  1  combinational; pipeline must hold its writeback this cycle.
- `reg_we_o`  out  1  registered write enable to the regfile.
- `reg_waddr_o`  out  RADDR_WIDTH  registered write address.
- `reg_wdata_o`  out  RDATA_WIDTH  registered write data.
- `buf_cnt_o`  out  2  buffer occupancy, 0..2.

## Operation
Request qualification:
- A pipeline request is effective only when `pipe_we_i`=1 and `pipe_waddr_i` != `ZERO_REG`.
- An mdu result is accepted on `mdu_valid_i && mdu_ready_o`.
- An accepted mdu result addressed to `ZERO_REG` is dropped and not enqueued.

Grant each cycle, priority order:
1. If the buffer is non-empty, `starve_cnt` == `STARVE_LIMIT` and the pipeline request is effective: the buffer head wins and `stall_o`=1. The pipeline holds its address and data into the next cycle.
2. Otherwise, if the pipeline request is effective: the pipeline wins.
3. Otherwise, if the buffer is non-empty: the buffer head wins and is dequeued.
4. Otherwise there is no write, and `reg_we_o`=0 next cycle.

`starve_cnt`:
- Increments when the buffer is non-empty and the pipeline wins.
- Clears when the buffer head is granted, and whenever the buffer is empty.
- Saturates at `STARVE_LIMIT`.

Buffer:
- FIFO order is preserved.
- `mdu_ready_o` is derived from the registered count only, so a full buffer does not accept even in a cycle where it also dequeues.
- An enqueue into an empty buffer is not eligible for grant until the next cycle (no bypass).
- Enqueue and dequeue in the same cycle leave the count unchanged.

Ordering:
- This block does not resolve WAW conflicts between the pipeline and the mdu to the same register.
- The issue-stage scoreboard guarantees none are in flight.

## Timing
- Latency: the winner in cycle N appears on `reg_*` in cycle N+1.
- mdu result latency: accept in N, earliest write on `reg_*` in N+2.
- While `rst_n_i`=0, independent of the clock:
  - `reg_we_o`=0, `reg_waddr_o`=`ZERO_REG`, `reg_wdata_o`=`ZERO`.
  - Buffer count 0, so `buf_cnt_o`=0 and `mdu_ready_o`=1.
  - `starve_cnt`=0.
  - `stall_o`=0.
- Reset asserted mid-operation discards buffered results. The mdu is reset by the same signal.
- `stall_o` is high for exactly one cycle per forced drain.
- A full buffer at limit drains one entry per stall. `starve_cnt` then restarts at 0, so there are at least `STARVE_LIMIT` pipeline writes between stalls.

## Structure
- `defines.v` supplies `ZERO_REG`, `ZERO`, `RADDR_WIDTH`, `RDATA_WIDTH` and a new `WB_BUF_DEPTH` (2).
- One sub-module, `wb_buf_fifo`: a 2-entry FIFO with push, pop, head, count and asynchronous active-low reset.
- `wb_port_arb` contains the grant logic, the starvation counter and the output register.

## Test plan
- Pipeline only: `pipe_we_i`=1, addr 5, data 0xA5 in cycle N → `reg_we_o`=1, addr 5, data 0xA5 in N+1; `stall_o` stays 0.
- Idle drain: mdu result addr 7, data 0x1234 with the pipeline idle → `buf_cnt_o`=1 in N+1; regfile write addr 7 in N+2; count 0 after.
- x0 filtering:
  - Pipeline write to addr 0 → `reg_we_o`=0.
  - mdu result to addr 0 accepted → `buf_cnt_o` stays 0.
- Starvation, `STARVE_LIMIT`=4: two mdu results buffered, pipeline writing every cycle:
  - After 4 pipeline grants, `stall_o`=1 for one cycle and the first mdu result is written.
  - 4 more pipeline grants, then a second stall writes the second result.
  - `mdu_ready_o`=0 while the count is 2.
- Full plus simultaneous events: buffer full, pipeline idle, `mdu_valid_i`=1 → the head dequeues, the new result is not accepted that cycle, and it is accepted the next cycle; FIFO order is preserved.
- Asynchronous reset with 2 entries buffered and `reg_we_o`=1 → all outputs reach reset values without a clock edge; `mdu_ready_o`=1; no write follows reset release.

Source files
------------

// File: rtl/wb_port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arb_pkg
// Purpose  : Shared constants and types for the regfile write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_port_arb_pkg;

   localparam int ZERO_REG     = 0;
   localparam int ZERO         = 0;
   localparam int WB_BUF_DEPTH = 2;
   localparam int STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_BUF  = 2'd2
   } gnt_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_port_arb_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_buf_fifo
// Purpose  : Two-entry FIFO holding mdu results waiting for the write port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_buf_fifo
   import wb_port_arb_pkg::*;
#(
   parameter int RADDR_WIDTH = 5,
   parameter int RDATA_WIDTH = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   push_i,
   input  logic [RADDR_WIDTH-1:0] push_addr_i,
   input  logic [RDATA_WIDTH-1:0] push_data_i,
   input  logic                   pop_i,
   output logic [RADDR_WIDTH-1:0] head_addr_o,
   output logic [RDATA_WIDTH-1:0] head_data_o,
   output logic [1:0]             count_o
);

   localparam int c_PTR_W = $clog2(WB_BUF_DEPTH);
   localparam int c_ENT_W = RADDR_WIDTH + RDATA_WIDTH;
   localparam logic [1:0] c_FULL = 2'(WB_BUF_DEPTH);

   logic [c_ENT_W-1:0] r_mem [WB_BUF_DEPTH];
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [1:0]         r_count;
   logic               w_push;
   logic               w_pop;

   assign w_push = push_i && (r_count != c_FULL);
   assign w_pop  = pop_i  && (r_count != 2'd0);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {push_addr_i, push_data_i};
      end
   end

   assign head_addr_o = r_mem[r_rd_ptr][c_ENT_W-1:RDATA_WIDTH];
   assign head_data_o = r_mem[r_rd_ptr][RDATA_WIDTH-1:0];
   assign count_o     = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arb
// Purpose  : Shares the regfile write port between pipeline writeback and
//            buffered mdu results, forcing a stall when the buffer starves.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arb
   import wb_port_arb_pkg::*;
#(
   parameter int RADDR_WIDTH  = 5,
   parameter int RDATA_WIDTH  = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   pipe_we_i,
   input  logic [RADDR_WIDTH-1:0] pipe_waddr_i,
   input  logic [RDATA_WIDTH-1:0] pipe_wdata_i,
   input  logic                   mdu_valid_i,
   output logic                   mdu_ready_o,
   input  logic [RADDR_WIDTH-1:0] mdu_waddr_i,
   input  logic [RDATA_WIDTH-1:0] mdu_wdata_i,
   output logic                   stall_o,
   output logic                   reg_we_o,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic [RDATA_WIDTH-1:0] reg_wdata_o,
   output logic [1:0]             buf_cnt_o
);

   localparam logic [STARVE_CNT_W-1:0] c_STARVE_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
   localparam logic [RADDR_WIDTH-1:0]  c_ZERO_REG     = RADDR_WIDTH'(ZERO_REG);
   localparam logic [RDATA_WIDTH-1:0]  c_ZERO         = RDATA_WIDTH'(ZERO);
   localparam logic [1:0]              c_BUF_FULL     = 2'(WB_BUF_DEPTH);

   logic [RADDR_WIDTH-1:0]  w_head_addr;
   logic [RDATA_WIDTH-1:0]  w_head_data;
   logic [1:0]              w_buf_cnt;
   logic                    w_buf_nonempty;
   logic                    w_pipe_eff;
   logic                    w_mdu_ready;
   logic                    w_mdu_push;
   logic                    w_force;
   gnt_src_e                w_gnt;
   logic [STARVE_CNT_W-1:0] r_starve_cnt;
   logic [STARVE_CNT_W-1:0] w_starve_nxt;
   logic                    r_reg_we;
   logic [RADDR_WIDTH-1:0]  r_reg_waddr;
   logic [RDATA_WIDTH-1:0]  r_reg_wdata;

   assign w_pipe_eff     = pipe_we_i && (pipe_waddr_i != c_ZERO_REG);
   assign w_buf_nonempty = (w_buf_cnt != 2'd0);
   // Ready looks only at the registered count, so a full buffer never
   // accepts even while its head is being written out.
   assign w_mdu_ready    = (w_buf_cnt != c_BUF_FULL);
   assign w_mdu_push     = mdu_valid_i && w_mdu_ready && (mdu_waddr_i != c_ZERO_REG);

   wb_buf_fifo #(
      .RADDR_WIDTH (RADDR_WIDTH),
      .RDATA_WIDTH (RDATA_WIDTH)
   ) u_buf (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .push_i      (w_mdu_push),
      .push_addr_i (mdu_waddr_i),
      .push_data_i (mdu_wdata_i),
      .pop_i       (w_gnt == GNT_BUF),
      .head_addr_o (w_head_addr),
      .head_data_o (w_head_data),
      .count_o     (w_buf_cnt)
   );

   always_comb begin
      w_gnt   = GNT_NONE;
      w_force = 1'b0;
      if (w_buf_nonempty && (r_starve_cnt == c_STARVE_LIMIT) && w_pipe_eff) begin
         w_force = 1'b1;
         w_gnt   = GNT_BUF;
      end else if (w_pipe_eff) begin
         w_gnt = GNT_PIPE;
      end else if (w_buf_nonempty) begin
         w_gnt = GNT_BUF;
      end
   end

   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (!w_buf_nonempty || (w_gnt == GNT_BUF)) begin
         w_starve_nxt = '0;
      end else if ((w_gnt == GNT_PIPE) && (r_starve_cnt != c_STARVE_LIMIT)) begin
         w_starve_nxt = r_starve_cnt + STARVE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_starve_cnt <= '0;
      end else begin
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // Address and data hold their last value when no write is granted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_reg_we    <= 1'b0;
         r_reg_waddr <= c_ZERO_REG;
         r_reg_wdata <= c_ZERO;
      end else begin
         case (w_gnt)
            GNT_PIPE: begin
               r_reg_we    <= 1'b1;
               r_reg_waddr <= pipe_waddr_i;
               r_reg_wdata <= pipe_wdata_i;
            end
            GNT_BUF: begin
               r_reg_we    <= 1'b1;
               r_reg_waddr <= w_head_addr;
               r_reg_wdata <= w_head_data;
            end
            default: begin
               r_reg_we <= 1'b0;
            end
         endcase
      end
   end

   assign stall_o     = w_force;
   assign mdu_ready_o = w_mdu_ready;
   assign buf_cnt_o   = w_buf_cnt;
   assign reg_we_o    = r_reg_we;
   assign reg_waddr_o = r_reg_waddr;
   assign reg_wdata_o = r_reg_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arb
// Purpose  : Self-checking bench for wb_port_arb (vector table, corner
//            sequences, randomized traffic against a queue-based model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arb;

   localparam int LIMIT = 4;

   logic        clk_i;
   logic        rst_n_i;
   logic        pipe_we_i;
   logic [4:0]  pipe_waddr_i;
   logic [31:0] pipe_wdata_i;
   logic        mdu_valid_i;
   logic        mdu_ready_o;
   logic [4:0]  mdu_waddr_i;
   logic [31:0] mdu_wdata_i;
   logic        stall_o;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
   logic [1:0]  buf_cnt_o;

   wb_port_arb #(
      .RADDR_WIDTH  (5),
      .RDATA_WIDTH  (32),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .pipe_we_i    (pipe_we_i),
      .pipe_waddr_i (pipe_waddr_i),
      .pipe_wdata_i (pipe_wdata_i),
      .mdu_valid_i  (mdu_valid_i),
      .mdu_ready_o  (mdu_ready_o),
      .mdu_waddr_i  (mdu_waddr_i),
      .mdu_wdata_i  (mdu_wdata_i),
      .stall_o      (stall_o),
      .reg_we_o     (reg_we_o),
      .reg_waddr_o  (reg_waddr_o),
      .reg_wdata_o  (reg_wdata_o),
      .buf_cnt_o    (buf_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   // Reference model: pending mdu results in arrival order, a starvation tally
   // and the write that should appear on the regfile port.
   ent_t        q[$];
   int          m_starve;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_stall;
   logic        m_ready;
   logic        m_acc;

   logic        a_stall;
   logic        a_ready;

   typedef struct {
      logic        pwe;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        mv;
      logic [4:0]  ma;
      logic [31:0] md;
      logic        estall;
      logic        eready;
      logic        ewe;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic [1:0]  ecnt;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_starve = 0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
   endtask

   task automatic model_step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                             input logic mv, input logic [4:0] ma, input logic [31:0] md);
      bit   peff;
      bit   ne;
      ent_t h;
      peff    = pwe && (pa != 5'd0);
      ne      = (q.size() != 0);
      m_stall = ne && (m_starve == LIMIT) && peff;
      m_ready = (q.size() < 2);
      m_acc   = mv && m_ready;
      if (m_stall || (ne && !peff)) begin
         h        = q.pop_front();
         m_we     = 1'b1;
         m_addr   = h.a;
         m_data   = h.d;
         m_starve = 0;
      end else if (peff) begin
         m_we     = 1'b1;
         m_addr   = pa;
         m_data   = pd;
         m_starve = ne ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else begin
         m_we     = 1'b0;
         m_starve = 0;
      end
      if (m_acc && (ma != 5'd0)) begin
         q.push_back('{a: ma, d: md});
      end
   endtask

   // One clock cycle: apply inputs, sample combinational outputs, advance model,
   // then sample registered outputs 1 ns after the rising edge.
   task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
      pipe_we_i    = pwe;
      pipe_waddr_i = pa;
      pipe_wdata_i = pd;
      mdu_valid_i  = mv;
      mdu_waddr_i  = ma;
      mdu_wdata_i  = md;
      #1;
      a_stall = stall_o;
      a_ready = mdu_ready_o;
      model_step(pwe, pa, pd, mv, ma, md);
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".stall"}, 32'(a_stall), 32'(m_stall));
      chk({tag, ".ready"}, 32'(a_ready), 32'(m_ready));
      chk({tag, ".we"}, 32'(reg_we_o), 32'(m_we));
      if (m_we) begin
         chk({tag, ".addr"}, 32'(reg_waddr_o), 32'(m_addr));
         chk({tag, ".data"}, reg_wdata_o, m_data);
      end
      chk({tag, ".cnt"}, 32'(buf_cnt_o), 32'(q.size()));
   endtask

   task automatic drive_idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   function automatic vec_t mk(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic es, input logic er, input logic ew,
                               input logic [4:0] ea, input logic [31:0] ed, input logic [1:0] ec);
      vec_t v;
      v.pwe = pwe; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
      v.estall = es; v.eready = er; v.ewe = ew; v.ea = ea; v.ed = ed; v.ecnt = ec;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        hold_pwe;
      logic [4:0]  hold_pa;
      logic [31:0] hold_pd;
      logic        hold_mv;
      logic [4:0]  hold_ma;
      logic [31:0] hold_md;
      logic        prev_stall;
      logic        mdu_pending;

      rst_n_i = 1'b0;
      pipe_we_i = 1'b0; pipe_waddr_i = '0; pipe_wdata_i = '0;
      mdu_valid_i = 1'b0; mdu_waddr_i = '0; mdu_wdata_i = '0;
      model_reset();

      // Reset values before any clock edge
      #2;
      chk("rst.we", 32'(reg_we_o), 32'd0);
      chk("rst.addr", 32'(reg_waddr_o), 32'd0);
      chk("rst.data", reg_wdata_o, 32'd0);
      chk("rst.cnt", 32'(buf_cnt_o), 32'd0);
      chk("rst.ready", 32'(mdu_ready_o), 32'd1);
      chk("rst.stall", 32'(stall_o), 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;

      //           pwe pa     pd        mv ma     md          st rd we ea     ed          cnt
      tbl[0]  = mk(1, 5'd5,  32'hA5,   0, 5'd0,  32'h0,      0, 1, 1, 5'd5,  32'hA5,     2'd0);
      tbl[1]  = mk(0, 5'd0,  32'h0,    1, 5'd7,  32'h1234,   0, 1, 0, 5'd0,  32'h0,      2'd1);
      tbl[2]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 1, 1, 5'd7,  32'h1234,   2'd0);
      tbl[3]  = mk(1, 5'd0,  32'hFF,   0, 5'd0,  32'h0,      0, 1, 0, 5'd0,  32'h0,      2'd0);
      tbl[4]  = mk(0, 5'd0,  32'h0,    1, 5'd0,  32'h55,     0, 1, 0, 5'd0,  32'h0,      2'd0);
      tbl[5]  = mk(1, 5'd1,  32'h11,   1, 5'd8,  32'h80,     0, 1, 1, 5'd1,  32'h11,     2'd1);
      tbl[6]  = mk(1, 5'd2,  32'h22,   1, 5'd9,  32'h90,     0, 1, 1, 5'd2,  32'h22,     2'd2);
      tbl[7]  = mk(1, 5'd3,  32'h33,   0, 5'd0,  32'h0,      0, 0, 1, 5'd3,  32'h33,     2'd2);
      tbl[8]  = mk(1, 5'd4,  32'h44,   0, 5'd0,  32'h0,      0, 0, 1, 5'd4,  32'h44,     2'd2);
      tbl[9]  = mk(1, 5'd5,  32'h55,   0, 5'd0,  32'h0,      0, 0, 1, 5'd5,  32'h55,     2'd2);
      tbl[10] = mk(1, 5'd6,  32'h66,   0, 5'd0,  32'h0,      1, 0, 1, 5'd8,  32'h80,     2'd1);
      tbl[11] = mk(1, 5'd6,  32'h66,   0, 5'd0,  32'h0,      0, 1, 1, 5'd6,  32'h66,     2'd1);
      tbl[12] = mk(1, 5'd7,  32'h77,   0, 5'd0,  32'h0,      0, 1, 1, 5'd7,  32'h77,     2'd1);
      tbl[13] = mk(1, 5'd10, 32'h0A,   0, 5'd0,  32'h0,      0, 1, 1, 5'd10, 32'h0A,     2'd1);
      tbl[14] = mk(1, 5'd11, 32'h0B,   0, 5'd0,  32'h0,      0, 1, 1, 5'd11, 32'h0B,     2'd1);
      tbl[15] = mk(1, 5'd12, 32'h0C,   0, 5'd0,  32'h0,      1, 1, 1, 5'd9,  32'h90,     2'd0);
      tbl[16] = mk(1, 5'd12, 32'h0C,   0, 5'd0,  32'h0,      0, 1, 1, 5'd12, 32'h0C,     2'd0);
      tbl[17] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 1, 0, 5'd0,  32'h0,      2'd0);

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md);
         chk($sformatf("tbl%0d.stall", i), 32'(a_stall), 32'(tbl[i].estall));
         chk($sformatf("tbl%0d.ready", i), 32'(a_ready), 32'(tbl[i].eready));
         chk($sformatf("tbl%0d.we", i), 32'(reg_we_o), 32'(tbl[i].ewe));
         if (tbl[i].ewe) begin
            chk($sformatf("tbl%0d.addr", i), 32'(reg_waddr_o), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d.data", i), reg_wdata_o, tbl[i].ed);
         end
         chk($sformatf("tbl%0d.cnt", i), 32'(buf_cnt_o), 32'(tbl[i].ecnt));
      end

      // Full buffer, idle pipeline, new result offered: not taken until next cycle
      drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd20, 32'h200);
      chk("full.a.cnt", 32'(buf_cnt_o), 32'd1);
      drive(1'b1, 5'd2, 32'h102, 1'b1, 5'd21, 32'h201);
      chk("full.b.cnt", 32'(buf_cnt_o), 32'd2);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'h202);
      chk("full.c.ready", 32'(a_ready), 32'd0);
      chk("full.c.addr", 32'(reg_waddr_o), 32'd20);
      chk("full.c.data", reg_wdata_o, 32'h200);
      chk("full.c.cnt", 32'(buf_cnt_o), 32'd1);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'h202);
      chk("full.d.ready", 32'(a_ready), 32'd1);
      chk("full.d.addr", 32'(reg_waddr_o), 32'd21);
      chk("full.d.cnt", 32'(buf_cnt_o), 32'd1);
      drive_idle();
      chk("full.e.we", 32'(reg_we_o), 32'd1);
      chk("full.e.addr", 32'(reg_waddr_o), 32'd22);
      chk("full.e.data", reg_wdata_o, 32'h202);
      chk("full.e.cnt", 32'(buf_cnt_o), 32'd0);

      // Randomized traffic; pipeline holds on stall, mdu holds until accepted
      prev_stall  = 1'b0;
      mdu_pending = 1'b0;
      hold_pwe = 1'b0; hold_pa = '0; hold_pd = '0;
      hold_mv  = 1'b0; hold_ma = '0; hold_md = '0;
      for (int n = 0; n < 400; n++) begin
         if (!prev_stall) begin
            hold_pwe = ($urandom_range(0, 3) != 0);
            hold_pa  = 5'($urandom_range(0, 31));
            hold_pd  = $urandom;
         end
         if (!mdu_pending) begin
            hold_mv = ($urandom_range(0, 9) < 4);
            hold_ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            hold_md = $urandom;
         end
         drive(hold_pwe, hold_pa, hold_pd, hold_mv, hold_ma, hold_md);
         check_model("rnd");
         prev_stall  = a_stall;
         mdu_pending = hold_mv && !m_acc;
      end

      // Asynchronous reset with two results buffered and a write on the port
      repeat (3) begin
         drive_idle();
         check_model("drain");
      end
      drive(1'b1, 5'd1, 32'h301, 1'b1, 5'd3, 32'h303);
      drive(1'b1, 5'd2, 32'h302, 1'b1, 5'd4, 32'h304);
      chk("arst.pre.we", 32'(reg_we_o), 32'd1);
      chk("arst.pre.cnt", 32'(buf_cnt_o), 32'd2);
      pipe_we_i    = 1'b1;
      pipe_waddr_i = 5'd3;
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("arst.we", 32'(reg_we_o), 32'd0);
      chk("arst.addr", 32'(reg_waddr_o), 32'd0);
      chk("arst.data", reg_wdata_o, 32'd0);
      chk("arst.cnt", 32'(buf_cnt_o), 32'd0);
      chk("arst.ready", 32'(mdu_ready_o), 32'd1);
      chk("arst.stall", 32'(stall_o), 32'd0);
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      repeat (2) begin
         drive_idle();
         check_model("post_rst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
